// File: rtl/led_sequencer.sv
// Paced four-LED pattern sequencer: owns the tick prescaler and pattern index,
// with run/hold/single-step/clear control and a mode/period configuration handshake.
module led_sequencer #(
    parameter int unsigned CLK_DIV = 12000000,
    parameter int unsigned DIV_W   = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             step,
    input  logic             clr,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_mode,
    input  logic [DIV_W-1:0] cfg_div,
    output logic [3:0]       leds,
    output logic             tick,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       leds_q, leds_d;
    logic             tick_q, tick_d;
    logic [3:0]       idx_q, idx_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             step_q;

    logic             cfg_fire;
    logic             mode_chg;
    logic             step_rise;
    logic [3:0]       idx_nxt;
    logic [DIV_W-1:0] div_last;

    // LED image for a given mode and pattern position.
    function automatic logic [3:0] pattern(input logic [1:0] m, input logic [3:0] i);
        logic [3:0] p;
        p = 4'b0000;
        case (m)
            2'd0: p = i;
            2'd1: p = 4'b0001 << i[1:0];
            2'd2: p = {4{i[0]}};
            default: begin
                case (i)
                    4'd0:    p = 4'b0001;
                    4'd1:    p = 4'b0010;
                    4'd2:    p = 4'b0100;
                    4'd3:    p = 4'b1000;
                    4'd4:    p = 4'b0100;
                    default: p = 4'b0010;
                endcase
            end
        endcase
        return p;
    endfunction

    // Next pattern position, wrapping at the mode-dependent sequence length.
    function automatic logic [3:0] next_idx(input logic [1:0] m, input logic [3:0] i);
        logic [3:0] last;
        case (m)
            2'd0:    last = 4'd15;
            2'd1:    last = 4'd3;
            2'd2:    last = 4'd1;
            default: last = 4'd5;
        endcase
        return (i >= last) ? 4'd0 : 4'(i + 4'd1);
    endfunction

    assign cfg_ready = (state_q == ST_IDLE) || (state_q == ST_HOLD);
    assign leds      = leds_q;
    assign tick      = tick_q;
    assign state     = state_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            leds_q    <= 4'b0000;
            tick_q    <= 1'b0;
            idx_q     <= 4'd0;
            div_cnt_q <= '0;
            mode_q    <= 2'd0;
            div_q     <= DIV_W'(CLK_DIV);
            step_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            leds_q    <= leds_d;
            tick_q    <= tick_d;
            idx_q     <= idx_d;
            div_cnt_q <= div_cnt_d;
            mode_q    <= mode_d;
            div_q     <= div_d;
            step_q    <= step;
        end
    end

    // Period of zero behaves as one: terminal count is then 0.
    assign div_last = (div_q == '0) ? '0 : div_q - DIV_W'(1);

    always_comb begin
        state_d   = state_q;
        leds_d    = leds_q;
        tick_d    = 1'b0;
        idx_d     = idx_q;
        div_cnt_d = div_cnt_q;
        mode_d    = mode_q;
        div_d     = div_q;
        cfg_fire  = cfg_valid && cfg_ready;
        mode_chg  = cfg_fire && (cfg_mode != mode_q);
        step_rise = step && !step_q;
        idx_nxt   = next_idx(mode_q, idx_q);

        if (cfg_fire) begin
            mode_d = cfg_mode;
            div_d  = cfg_div;
        end

        if (clr) begin
            state_d   = ST_IDLE;
            idx_d     = 4'd0;
            leds_d    = 4'b0000;
            div_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    leds_d = 4'b0000;
                    if (run) begin
                        state_d   = ST_RUN;
                        idx_d     = 4'd0;
                        div_cnt_d = '0;
                        leds_d    = pattern(mode_d, 4'd0);
                    end
                end
                ST_RUN: begin
                    if (!run) begin
                        state_d   = ST_HOLD;
                        div_cnt_d = '0;
                    end else if (div_cnt_q >= div_last) begin
                        div_cnt_d = '0;
                        idx_d     = idx_nxt;
                        leds_d    = pattern(mode_q, idx_nxt);
                        tick_d    = 1'b1;
                    end else begin
                        div_cnt_d = div_cnt_q + DIV_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (mode_chg) begin
                        idx_d  = 4'd0;
                        leds_d = pattern(mode_d, 4'd0);
                    end
                    // Resuming wins over a coincident step edge.
                    if (run) begin
                        state_d   = ST_RUN;
                        div_cnt_d = '0;
                    end else if (step_rise && !mode_chg) begin
                        idx_d  = idx_nxt;
                        leds_d = pattern(mode_q, idx_nxt);
                        tick_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = 4'd0;
                    leds_d  = 4'b0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer: stimulus pushes expected (cycle, leds) per advance,
// a monitor pops one entry on every tick pulse; a table-driven model tracks mode/period/position.
module tb_led_sequencer;

    localparam int unsigned TB_DIV_W   = 24;
    localparam int unsigned TB_CLK_DIV = 20;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                run;
    logic                step;
    logic                clr;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [1:0]          cfg_mode;
    logic [TB_DIV_W-1:0] cfg_div;
    logic [3:0]          leds;
    logic                tick;
    logic [1:0]          state;

    led_sequencer #(
        .CLK_DIV (TB_CLK_DIV),
        .DIV_W   (TB_DIV_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .step      (step),
        .clr       (clr),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_mode  (cfg_mode),
        .cfg_div   (cfg_div),
        .leds      (leds),
        .tick      (tick),
        .state     (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] leds;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errs = 0;

    // Reference model: sequence tables plus mode, period, position.
    logic [3:0] tbl [4][16];
    int         len [4];
    int         m_mode;
    int         m_div;
    int         m_pos;
    bit         m_idle;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: each tick pulse must match the oldest expected advance.
    always @(negedge clk) begin
        if (tick === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL unexpected_tick: got leds %0h with no advance expected (cycle %0d)", leds, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("tick_leds", 32'(leds), 32'(e.leds));
                chk("tick_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic push(input int c, input logic [3:0] l);
        exp_t e;
        e.cyc  = c;
        e.leds = l;
        exp_q.push_back(e);
    endtask

    task automatic apply_cfg(input int md, input int dv);
        if (md != m_mode) m_pos = 0;
        m_mode = md;
        m_div  = dv;
    endtask

    task automatic do_cfg(input int md, input int dv);
        chk("cfg_ready_rest", 32'(cfg_ready), 32'd1);
        cfg_valid = 1'b1;
        cfg_mode  = 2'(md);
        cfg_div   = TB_DIV_W'(dv);
        @(negedge clk);
        cfg_valid = 1'b0;
        apply_cfg(md, dv);
        chk("cfg_leds", 32'(leds), m_idle ? 32'd0 : 32'(tbl[m_mode][m_pos]));
    endtask

    // Run for n active edges, then end by dropping run (0), clr (1) or reset (2).
    task automatic do_run(input int n, input int ending, input bit offer, input int om, input int od);
        int e;
        int d;
        int p0;
        int cnt;
        e   = cyc + 1;
        d   = (m_div == 0) ? 1 : m_div;
        p0  = m_idle ? 0 : m_pos;
        cnt = (n - 1) / d;
        for (int k = 1; k <= cnt; k++) push(e + k * d, tbl[m_mode][(p0 + k) % len[m_mode]]);
        run = 1'b1;
        @(negedge clk);
        chk("run_entry_state", 32'(state), 32'd1);
        chk("run_entry_leds", 32'(leds), 32'(tbl[m_mode][p0]));
        if (offer) begin
            cfg_valid = 1'b1;
            cfg_mode  = 2'(om);
            cfg_div   = TB_DIV_W'(od);
        end
        repeat (n - 1) begin
            if (offer) chk("cfg_ready_in_run", 32'(cfg_ready), 32'd0);
            @(negedge clk);
        end
        run = 1'b0;
        if (ending == 1) clr = 1'b1;
        if (ending == 2) rst_n = 1'b0;
        @(negedge clk);
        clr    = 1'b0;
        rst_n  = 1'b1;
        m_pos  = (p0 + cnt) % len[m_mode];
        m_idle = 1'b0;
        if (ending == 0) begin
            chk("hold_state", 32'(state), 32'd2);
            chk("hold_leds", 32'(leds), 32'(tbl[m_mode][m_pos]));
            if (offer) begin
                chk("cfg_ready_hold", 32'(cfg_ready), 32'd1);
                @(negedge clk);
                cfg_valid = 1'b0;
                apply_cfg(om, od);
                chk("stalled_cfg_leds", 32'(leds), 32'(tbl[m_mode][m_pos]));
            end
        end else begin
            m_idle = 1'b1;
            m_pos  = 0;
            if (ending == 2) begin
                m_mode = 0;
                m_div  = TB_CLK_DIV;
            end
            chk("stop_state", 32'(state), 32'd0);
            chk("stop_leds", 32'(leds), 32'd0);
            chk("stop_tick", 32'(tick), 32'd0);
        end
    endtask

    task automatic do_step(input int hold);
        m_pos = (m_pos + 1) % len[m_mode];
        push(cyc + 1, tbl[m_mode][m_pos]);
        step = 1'b1;
        repeat (hold) @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        chk("step_leds", 32'(leds), 32'(tbl[m_mode][m_pos]));
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        clr    = 1'b0;
        m_idle = 1'b1;
        m_pos  = 0;
        chk("clr_state", 32'(state), 32'd0);
        chk("clr_leds", 32'(leds), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int m = 0; m < 4; m++) for (int i = 0; i < 16; i++) tbl[m][i] = 4'b0000;
        for (int i = 0; i < 16; i++) tbl[0][i] = 4'(i);
        for (int i = 0; i < 4; i++) tbl[1][i] = 4'(1 << i);
        tbl[2][0] = 4'b0000;
        tbl[2][1] = 4'b1111;
        tbl[3][0] = 4'b0001; tbl[3][1] = 4'b0010; tbl[3][2] = 4'b0100;
        tbl[3][3] = 4'b1000; tbl[3][4] = 4'b0100; tbl[3][5] = 4'b0010;
        len[0] = 16; len[1] = 4; len[2] = 2; len[3] = 6;

        rst_n = 1'b0; run = 1'b0; step = 1'b0; clr = 1'b0;
        cfg_valid = 1'b0; cfg_mode = 2'd0; cfg_div = '0;
        m_mode = 0; m_div = TB_CLK_DIV; m_pos = 0; m_idle = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_leds", 32'(leds), 32'd0);
        chk("reset_tick", 32'(tick), 32'd0);
        chk("reset_cfg_ready", 32'(cfg_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Binary, period 3, full wrap after 16 advances.
        do_cfg(0, 3);
        do_run(49, 0, 1'b0, 0, 0);
        chk("binary_wrap_leds", 32'(leds), 32'd0);

        // Chase at period 1, then period 0 treated as 1.
        do_cfg(1, 1);
        do_run(9, 0, 1'b0, 0, 0);
        do_cfg(1, 0);
        do_run(6, 0, 1'b0, 0, 0);

        // Bounce at period 2.
        do_cfg(3, 2);
        do_run(14, 0, 1'b0, 0, 0);

        // Hold at 0100, held step gives one advance, run+step gives no step advance.
        do_cfg(1, 1);
        do_run(3, 0, 1'b0, 0, 0);
        chk("hold_at_0100", 32'(leds), 32'b0100);
        chk("hold_cfg_ready", 32'(cfg_ready), 32'd1);
        do_step(5);
        chk("step_to_1000", 32'(leds), 32'b1000);
        step = 1'b1;
        do_run(3, 0, 1'b0, 0, 0);
        step = 1'b0;
        @(negedge clk);

        // Config offered during RUN stalls until HOLD, then blink at the new period.
        do_run(5, 0, 1'b1, 2, 2);
        chk("blink_hold_leds", 32'(leds), 32'd0);
        do_run(9, 0, 1'b0, 0, 0);

        // Clear mid-run keeps mode/period; reset mid-run restores defaults.
        do_run(7, 1, 1'b0, 0, 0);
        do_run(5, 2, 1'b0, 0, 0);
        do_run(TB_CLK_DIV + 1, 0, 1'b0, 0, 0);
        chk("post_reset_first_adv", 32'(leds), 32'b0001);

        // Randomized mix of configuration, run bursts, steps and clears.
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 4))
                0: do_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
                1, 2: do_run(int'($urandom_range(1, 20)), 0, 1'b0, 0, 0);
                3: if (!m_idle) do_step(int'($urandom_range(1, 3)));
                default: do_clr();
            endcase
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
Controller for the four-LED counter datapath. It owns the tick prescaler and the pattern index, and schedules when the LED outputs advance. It provides a configuration handshake for pattern mode and tick period, and supports run, hold, single-step and clear control. It sits between board-level controls or a host register interface and the LED pins, and replaces free-running per-clock counting with a programmable, paced sequence.

Parameters:
CLK_DIV, 12000000, reset value of the tick period in clk cycles (1 s at 12 MHz)
DIV_W, 24, width of the prescaler counter and of cfg_div

Ports:
clk  input  1  system clock, all logic on its rising edge
rst_n  input  1  synchronous active-low reset
run  input  1  level; 1 = advance pattern on ticks, 0 = hold
step  input  1  rising edge advances the pattern one position while in HOLD
clr  input  1  synchronous clear to IDLE; highest priority after reset
cfg_valid  input  1  configuration offer
cfg_ready  output  1  configuration can be accepted this cycle
cfg_mode  input  2  pattern mode, captured on handshake
cfg_div  input  DIV_W  tick period in cycles, captured on handshake
leds  output  4  LED drive, registered
tick  output  1  one-cycle pulse on every pattern advance
state  output  2  0 = IDLE, 1 = RUN, 2 = HOLD

Behaviour:
- Reset (rst_n = 0 at a clock edge):
  - state = IDLE, leds = 0000, tick = 0, idx = 0, div_cnt = 0
  - mode = 0, div = CLK_DIV, step edge-detect register = 0
- Priority each edge: rst_n, then clr, then state transitions, then step.
- clr = 1: state = IDLE, idx = 0, leds = 0000, tick = 0, div_cnt = 0. mode and div are retained.
- State transitions:
  - IDLE -> RUN when run = 1: idx = 0, div_cnt = 0, leds = pattern(mode, 0) on that same edge.
  - RUN -> HOLD when run = 0: leds and idx frozen, div_cnt = 0.
  - HOLD -> RUN when run = 1: continue from the current idx, div_cnt = 0.
  - There is no direct RUN -> IDLE transition; only clr or reset returns to IDLE.
- Prescaler, RUN only:
  - div_cnt increments every cycle.
  - On the edge where div_cnt == div - 1: div_cnt = 0, idx advances, leds update, and tick = 1 for exactly one cycle.
  - First advance occurs div cycles after entering RUN.
  - div = 0 is treated as 1, which gives an advance every cycle.
- Step:
  - step is detected on its rising edge (registered previous value).
  - In HOLD, each rising edge advances idx once and pulses tick. Holding step high gives one advance only.
  - step is ignored in IDLE and RUN.
  - If run = 1 in HOLD, the transition to RUN wins and step is ignored that cycle.
- Config handshake:
  - cfg_ready = 1 in IDLE and HOLD, 0 in RUN (combinational from state).
  - Transfer happens when cfg_valid and cfg_ready are both 1 at an edge: mode = cfg_mode, div = cfg_div.
  - If mode changes, idx = 0; in HOLD, leds update to pattern(new mode, 0) on the same edge.
  - A transfer in the same edge as IDLE -> RUN is accepted, and RUN starts with the new mode and div.
  - cfg_valid held in RUN stalls until HOLD or IDLE.
- Patterns, leds = pattern(mode, idx):
  - Mode 0, binary: idx 0..15, leds = idx, wraps 15 -> 0.
  - Mode 1, chase: idx 0..3, leds = 0001, 0010, 0100, 1000, wraps to 0001.
  - Mode 2, blink: idx 0..1, leds = 0000, 1111, alternating.
  - Mode 3, bounce: idx 0..5, leds = 0001, 0010, 0100, 1000, 0100, 0010, wraps to 0001.
- idx is 4 bits, and its wrap point depends on mode.
- leds = 0000 whenever state = IDLE.

Test Plan:
- Reset, then cfg mode 0, div 3, run = 1: leds read 0000, then 0001 three cycles after RUN entry, then 0010 three cycles later. tick pulses once per advance. After 16 advances leds = 0000 again (wrap).
- Mode 1, div 1, run: leds step 0001, 0010, 0100, 1000, 0001 on consecutive cycles. tick stays high continuously. cfg_div = 0 behaves identically to div 1.
- Mode 3, div 2, run for 14 cycles: leds sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001, with each advance two cycles apart.
- Run, drop run at leds = 0100 (mode 1): leds hold 0100 and cfg_ready = 1. step held high for 5 cycles gives exactly one advance to 1000 and one tick. Raising run and step in the same cycle gives RUN with no step advance.
- In RUN with cfg_valid = 1: no transfer while cfg_ready = 0. Drop run: transfer of mode 2 happens on the first HOLD edge, and leds = 0000. Raise run: leds alternate 1111 and 0000 at the new div.
- Assert clr mid-RUN: next edge gives state IDLE, leds 0000, tick 0. Then assert rst_n = 0 in RUN: mode = 0 and div = CLK_DIV. Restart: first advance occurs after CLK_DIV cycles.
